// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable integer clock-divider controller.
//
// Produces a registered divided waveform (clk_out) from clk. The divide ratio
// can be changed at runtime through a valid/ready handshake; a new ratio
// only takes effect on a period boundary, so no runt or stretched pulses.
//
// State | Meaning
// IDLE  | stopped, cnt=0, clk_out=0
// RUN   | counting, tick at every cnt==0
// DRAIN | run_en dropped, finishing the current period without tick
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   run_en     1 = produce output, 0 = stop at end of current period
//   cfg_valid  new divide ratio offered
//   cfg_div    requested divide ratio N
//   cfg_ready  controller can accept a ratio
//   cfg_err    one-cycle pulse when an offered ratio (N<2) is rejected
//   clk_out    divided waveform, high for ceil(N/2) cycles of each period
//   tick       one-cycle pulse in the first cycle of each started period
//   cur_div    ratio currently in effect
//   busy       not IDLE
module clk_div_ctrl #(
    parameter int          DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic [DIV_W-1:0] cur_div,
    output logic             busy
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_n;
    logic [DIV_W-1:0] cur_div_n;
    logic [DIV_W-1:0] pending_div;
    logic [DIV_W-1:0] pending_div_n;
    logic             pending;
    logic             pending_n;
    logic             accept;
    logic             ratio_ok;
    logic             wrap;
    logic [DIV_W:0]   high_len;

    always_comb begin
        accept        = cfg_valid && cfg_ready;
        ratio_ok      = (cfg_div >= DIV_W'(2));
        wrap          = (state != IDLE) && (cnt == cur_div - 1'b1);
        state_n       = state;
        cnt_n         = cnt;
        cur_div_n     = cur_div;
        pending_n     = pending;
        pending_div_n = pending_div;

        if (state == IDLE) begin
            cnt_n   = '0;
            state_n = run_en ? RUN : IDLE;
            // A ratio accepted in the very last cycle before stopping has no
            // further boundary to wait for, so it is applied from IDLE.
            if (pending) begin
                cur_div_n = pending_div;
                pending_n = 1'b0;
            end
            if (accept && ratio_ok) begin
                cur_div_n = cfg_div;
            end
        end else begin
            cnt_n = wrap ? '0 : cnt + 1'b1;
            if (run_en) begin
                state_n = RUN;
            end else if (wrap) begin
                state_n = IDLE;
            end else begin
                state_n = DRAIN;
            end
            // Only a ratio pending before this cycle is applied here; one
            // accepted in the boundary cycle waits for the next boundary.
            if (wrap && pending) begin
                cur_div_n = pending_div;
                pending_n = 1'b0;
            end
            if (accept && ratio_ok) begin
                pending_div_n = cfg_div;
                pending_n     = 1'b1;
            end
        end

        // Extra bit so the maximum ratio does not overflow on the +1.
        high_len = ({1'b0, cur_div_n} + 1'b1) >> 1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            cur_div     <= DEF_DIV;
            pending     <= 1'b0;
            pending_div <= DEF_DIV;
            cfg_ready   <= 1'b1;
            cfg_err     <= 1'b0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cur_div     <= cur_div_n;
            pending     <= pending_n;
            pending_div <= pending_div_n;
            cfg_ready   <= !pending_n;
            cfg_err     <= accept && !ratio_ok;
            // Outputs derive from next-state values so they line up with cnt.
            clk_out     <= (state_n != IDLE) && ({1'b0, cnt_n} < high_len);
            tick        <= (state_n == RUN) && (cnt_n == '0);
            busy        <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

    logic       clk;
    logic       reset;
    logic       run_en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       clk_out;
    logic       tick;
    logic [7:0] cur_div;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    clk_div_ctrl #(.DIV_W(8), .DEFAULT_DIV(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .run_en    (run_en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .cur_div   (cur_div),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position within the period, period length, and
    // whether the output is on / finishing its last period.
    bit m_on, m_draining, m_pend, m_ready, m_err, m_out, m_tick;
    int m_pos, m_div, m_pdiv;

    task automatic model_update(input bit r, input bit run, input bit v, input int d);
        bit acc_ok;
        bit acc_bad;
        bit last;
        int new_div;
        bit new_pend;
        if (r) begin
            m_on = 0; m_draining = 0; m_pos = 0; m_div = 6; m_pend = 0;
            m_pdiv = 6; m_ready = 1; m_err = 0; m_out = 0; m_tick = 0;
            return;
        end
        acc_ok   = v && m_ready && d >= 2;
        acc_bad  = v && m_ready && d < 2;
        last     = m_on && (m_pos == m_div - 1);
        new_div  = m_div;
        new_pend = m_pend;
        if (m_pend && (!m_on || last)) begin
            new_div  = m_pdiv;
            new_pend = 0;
        end
        if (acc_ok) begin
            if (!m_on) new_div = d;
            else begin
                new_pend = 1;
                m_pdiv   = d;
            end
        end
        if (!m_on) begin
            m_on = run; m_draining = 0; m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % m_div;
            if (run) m_draining = 0;
            else if (m_pos == 0) begin m_on = 0; m_draining = 0; end
            else m_draining = 1;
        end
        m_div   = new_div;
        m_pend  = new_pend;
        m_ready = !m_pend;
        m_err   = acc_bad;
        m_out   = m_on && (m_pos < (m_div + 1) / 2);
        m_tick  = m_on && !m_draining && (m_pos == 0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit run, input bit v, input int d);
        reset = r; run_en = run; cfg_valid = v; cfg_div = 8'(d);
        @(posedge clk);
        model_update(r, run, v, d);
        #1;
        chk("model_clk_out", int'(clk_out), int'(m_out));
        chk("model_tick", int'(tick), int'(m_tick));
        chk("model_cfg_ready", int'(cfg_ready), int'(m_ready));
        chk("model_cfg_err", int'(cfg_err), int'(m_err));
        chk("model_busy", int'(busy), int'(m_on));
        chk("model_cur_div", int'(cur_div), m_div);
    endtask

    typedef struct {
        bit rst, run, v;
        int d;
        bit out, tck, rdy, err, bsy;
        int div;
    } vec_t;

    vec_t tbl[21];

    initial begin
        bit run_r;
        int tick_cnt;
        reset = 1'b1; run_en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;

        // rst run v d | out tick ready err busy div
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 6};
        tbl[1]  = '{0, 1, 0, 0, 1, 1, 1, 0, 1, 6};
        tbl[2]  = '{0, 1, 0, 0, 1, 0, 1, 0, 1, 6};
        tbl[3]  = '{0, 1, 0, 0, 1, 0, 1, 0, 1, 6};
        tbl[4]  = '{0, 1, 0, 0, 0, 0, 1, 0, 1, 6};
        tbl[5]  = '{0, 1, 0, 0, 0, 0, 1, 0, 1, 6};
        tbl[6]  = '{0, 1, 0, 0, 0, 0, 1, 0, 1, 6};
        tbl[7]  = '{0, 1, 0, 0, 1, 1, 1, 0, 1, 6};
        tbl[8]  = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 6};
        tbl[9]  = '{0, 1, 0, 0, 1, 0, 1, 0, 1, 6};
        tbl[10] = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 6};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 6};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 6};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 6};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 6};
        tbl[15] = '{0, 1, 1, 5, 1, 1, 1, 0, 1, 5};
        tbl[16] = '{0, 1, 0, 0, 1, 0, 1, 0, 1, 5};
        tbl[17] = '{0, 1, 0, 0, 1, 0, 1, 0, 1, 5};
        tbl[18] = '{0, 1, 0, 0, 0, 0, 1, 0, 1, 5};
        tbl[19] = '{0, 1, 0, 0, 0, 0, 1, 0, 1, 5};
        tbl[20] = '{0, 1, 0, 0, 1, 1, 1, 0, 1, 5};

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].rst, tbl[i].run, tbl[i].v, tbl[i].d);
            chk("tbl_clk_out", int'(clk_out), int'(tbl[i].out));
            chk("tbl_tick", int'(tick), int'(tbl[i].tck));
            chk("tbl_cfg_ready", int'(cfg_ready), int'(tbl[i].rdy));
            chk("tbl_cfg_err", int'(cfg_err), int'(tbl[i].err));
            chk("tbl_busy", int'(busy), int'(tbl[i].bsy));
            chk("tbl_cur_div", int'(cur_div), tbl[i].div);
        end

        // Ratio change mid-period: accepted at cnt=2, applied at boundary.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 4);
        chk("chg_ready_low", int'(cfg_ready), 0);
        chk("chg_div_old", int'(cur_div), 6);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("chg_ready_still_low", int'(cfg_ready), 0);
        chk("chg_old_period_low", int'(clk_out), 0);
        step(0, 1, 0, 0);
        chk("chg_div_new", int'(cur_div), 4);
        chk("chg_ready_back", int'(cfg_ready), 1);
        chk("chg_tick", int'(tick), 1);
        step(0, 1, 0, 0);
        chk("chg_n4_cnt1", int'(clk_out), 1);
        step(0, 1, 0, 0);
        chk("chg_n4_cnt2", int'(clk_out), 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("chg_n4_wrap_tick", int'(tick), 1);

        // run_en dropped at cnt=1: period completes, then idle with no tick.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            chk("drain_busy", int'(busy), 1);
            chk("drain_no_tick", int'(tick), 0);
        end
        step(0, 0, 0, 0);
        chk("drain_done_busy", int'(busy), 0);
        chk("drain_done_out", int'(clk_out), 0);
        tick_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0);
            tick_cnt += int'(tick);
        end
        chk("idle_tick_count", tick_cnt, 0);

        // run_en dropped at cnt=1, reasserted at cnt=3: no gap.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("reassert_busy", int'(busy), 1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("reassert_tick", int'(tick), 1);
        chk("reassert_out", int'(clk_out), 1);

        // Pending ratio discarded by reset.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 3);
        chk("pend_ready_low", int'(cfg_ready), 0);
        step(1, 1, 0, 0);
        chk("pend_rst_div", int'(cur_div), 6);
        chk("pend_rst_ready", int'(cfg_ready), 1);
        chk("pend_rst_out", int'(clk_out), 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
        chk("pend_restart_div", int'(cur_div), 6);
        chk("pend_restart_tick", int'(tick), 1);

        // Randomized run against the reference model.
        step(1, 0, 0, 0);
        run_r = 0;
        for (int i = 0; i < 3000; i++) begin
            int d;
            if ($urandom_range(0, 9) == 0) run_r = !run_r;
            d = ($urandom_range(0, 39) == 0) ? 255 : int'($urandom_range(0, 12));
            step($urandom_range(0, 199) == 0, run_r, $urandom_range(0, 7) == 0, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Programmable integer clock-divider controller that generates a divided clock-enable waveform `clk_out` from `clk`.
- The divide ratio is reconfigured at runtime through a valid/ready interface. A new ratio takes effect only on a period boundary, so no runt or stretched pulses appear.
- `run_en` starts the output, and stops it cleanly at the end of a period. The block sits between the configuration logic and the divided-clock consumers, replacing fixed-ratio dividers.

Parameters:
DIV_W, 8, width of the divide-ratio field.
DEFAULT_DIV, 6, divide ratio after reset; legal range 2..2^DIV_W-1.

Ports:
clk  in  1  system clock.
reset  in  1  reset, synchronous, active-high.
run_en  in  1  level; 1 = produce divided output, 0 = stop at end of current period.
cfg_valid  in  1  new divide ratio offered.
cfg_div  in  DIV_W  requested divide ratio N.
cfg_ready  out  1  controller can accept a ratio.
cfg_err  out  1  one-cycle pulse: rejected ratio (N<2).
clk_out  out  1  divided waveform, registered.
tick  out  1  one-cycle pulse in the first cycle of each started period.
cur_div  out  DIV_W  ratio currently in effect.
busy  out  1  state != IDLE.

Behaviour:
Reset and input sampling:
- Reset values: state=IDLE, cnt=0, cur_div=DEFAULT_DIV, pending=0, cfg_ready=1, cfg_err=0, clk_out=0, tick=0, busy=0.
- All inputs are ignored while reset is high.
- Reset mid-run aborts the period immediately and discards any pending ratio.

Counter and waveform:
- Counter cnt runs 0..cur_div-1, then wraps to 0.
- high_len = (cur_div+1)>>1, i.e. ceil(N/2).
- In RUN/DRAIN, clk_out=1 in a cycle where cnt<high_len, else 0. Even N gives 50% duty; odd N has one extra high cycle.
- clk_out is driven from a flop, computed from the next-state cnt, so its value always corresponds to the cnt of the same cycle.

States:
- IDLE: cnt=0, clk_out=0.
  - run_en=1 -> RUN. The next cycle has cnt=0, clk_out=1, tick=1.
- RUN: cnt increments every cycle.
  - tick=1 whenever cnt==0.
  - run_en=0 sampled -> DRAIN; counting continues.
- DRAIN: finishes the current period; no tick.
  - At cnt==cur_div-1 -> IDLE (next cycle clk_out=0, busy=0).
  - run_en=1 sampled in DRAIN -> back to RUN with no gap or phase change.

Configuration:
- Transfer occurs when cfg_valid && cfg_ready.
- Invalid ratio: cfg_div<2 -> cfg_err=1 for exactly the next cycle; nothing else changes.
- Valid ratio in IDLE: cur_div <= cfg_div on the same edge; cfg_ready stays 1. If run_en=1 in the same cycle, the first RUN period uses the new ratio.
- Valid ratio in RUN/DRAIN: stored as pending_div, pending=1, and cfg_ready=0 from the next cycle.
  - It is applied at the edge where cnt==cur_div-1: cur_div <= pending_div, pending=0, cnt -> 0.
  - cfg_ready returns to 1 in the cycle after application.
- Acceptance in the boundary cycle itself (cnt==cur_div-1) is NOT applied at that boundary; it waits for the next one.
- A pending ratio that completes in DRAIN is applied on the transition to IDLE.
- The current period always completes with the old ratio; the new ratio starts exactly at the following cnt=0.

Width rules:
- cnt is DIV_W bits. Compares are unsigned.
- high_len is computed in DIV_W+1 bits, so N=2^DIV_W-1 does not overflow.

Test Plan:
1. Reset, then run_en=1 with default N=6 -> clk_out repeats 1,1,1,0,0,0; tick every 6 cycles starting first RUN cycle; cur_div=6; busy=1.
2. In IDLE, cfg_div=5 accepted, run_en=1 same cycle -> clk_out repeats 1,1,1,0,0; cur_div=5 immediately; cfg_ready never drops.
3. N=6 running, cfg_div=4 accepted at cnt=2 -> current period completes 6 cycles; cfg_ready=0 until cycle after boundary; then 1,1,0,0 pattern; cur_div=4 from boundary.
4. cfg_div=1 (and 0) offered while running -> cfg_err pulses one cycle; cur_div, waveform and cfg_ready unchanged.
5. N=6, run_en dropped at cnt=1 -> waveform completes through cnt=5, then clk_out=0, busy=0, no further tick. Repeat with run_en reasserted at cnt=3 -> uninterrupted periods with a tick at the next cnt=0.
6. Pending ratio (cfg 3 accepted mid-period), then reset asserted before boundary -> after reset cur_div=6, cfg_ready=1, clk_out=0; restart shows N=6 pattern.
